muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide controller in the EX stage, next to the ALU. It accepts MULT/MULTU/DIV/DIVU from the pipeline and runs a 32-iteration shift-add multiplier or restoring divider. Results are held in architectural HI/LO registers. The block stalls the pipeline when a new mul/div or an MFHI/MFLO read arrives while an operation is still in flight.

## Interface
- XLEN, 32, operand width; only 32 is supported.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  mul/div request from EX; valid with op/op_a/op_b.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU; other codes ignore start.
- op_a  in  32  rs (multiplicand / dividend).
- op_b  in  32  rt (multiplier / divisor).
- rd_req  in  1  MFHI/MFLO in EX wants hi/lo this cycle.
- flush  in  1  abort the in-flight operation (branch/exception squash).
- busy  out  1  operation in flight.
- stall  out  1  combinational: busy & (start | rd_req).
- done  out  1  one-cycle pulse; hi/lo were updated on the same edge.
- hi  out  32  HI register (product[63:32] / remainder).
- lo  out  32  LO register (product[31:0] / quotient).
- div_zero  out  1  present only with MULDIV_DIVZERO_FLAG_EN; pulses with done when divisor was 0.

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE: start with a legal op is captured at edge E; next state PREP.
  - Captured: op, sign of each operand, |op_a|, |op_b| (magnitudes only for signed ops), divisor-zero flag.
- PREP: clears the 64-bit accumulator and the 5-bit counter; next state RUN.
- RUN: one iteration per cycle; counter 0..31; at count 31, next state FIX.
  - Multiply: LSB-first shift-add into the 64-bit accumulator.
  - Divide: restoring step; 33-bit trial subtract, quotient bit shifted in.
- FIX: apply signs, write hi/lo, pulse done, go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Unsigned ops: no fix-up.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=op_a.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- start while busy is ignored; stall holds the requester, which re-presents start after busy falls.
- flush: synchronous, any non-IDLE state goes to IDLE on the next edge; hi/lo unchanged, no done. flush in IDLE with start: start is ignored.
- rd_req in the done cycle does not stall; hi/lo already hold the new result.
- Reset mid-operation: immediate return to IDLE; all registers cleared.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, div_zero=0, state IDLE; stall=0.
- Latency, start accepted at edge E:
  - PREP after E; RUN iterations on edges E+2..E+33; FIX writes on edge E+34.
  - busy=1 for the 34 cycles after E; done=1 for one cycle after E+34.
- Back-to-back: start in the done cycle is accepted; no bubble beyond the stall.
- stall has no register delay: the same cycle start/rd_req meets busy.

## Configuration
- MULDIV_DIVZERO_FLAG_EN defined:
  - The div_zero port exists.
  - A zero divisor is detected in PREP, which jumps directly to FIX.
  - Result on edge E+2; done and div_zero pulse in the following cycle.
- Undefined:
  - No div_zero port.
  - Division by zero runs the full 34-cycle sequence.
  - FIX forces the same LO=0xFFFFFFFF, HI=op_a values.

## Test plan
- MULT op_a=0xFFFFFFFE (-2), op_b=3 -> done at E+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV op_a=-7, op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - With the macro: done one cycle after E+2, div_zero=1.
  - Without it: done one cycle after E+34.
- rd_req asserted at E+10 -> stall=1 until busy falls; rd_req in the done cycle -> stall=0, new hi/lo visible.
- flush at E+20 -> busy=0 after the next edge, no done, hi/lo keep previous values; new start accepted immediately after.
- rst asserted mid-RUN (asynchronous, between edges) -> busy, done, hi, lo = 0 at once; start after rst release completes normally in 34 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 32-step shift-add multiply / restoring divide into HI/LO.
// Optional macro MULDIV_DIVZERO_FLAG_EN adds the div_zero port and an early-out for zero divisors.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            rd_req,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
`ifdef MULDIV_DIVZERO_FLAG_EN
    ,
    output logic            div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_e;

    state_e            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              bz_q, bz_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic              dz_q, dz_d;
`endif

    logic              is_signed;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [4:0]        div_idx;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;

    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;

    // Operands stay put; the counter indexes multiplier bits LSB-first and dividend bits MSB-first.
    assign div_idx = ~cnt_q;
    assign msum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[cnt_q] ? {1'b0, a_q} : '0);
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], a_q[div_idx]};
    assign trial   = {1'b0, rem_sh} - {2'b00, b_q};

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo      = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
        dz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && !op[2] && !flush) begin
                    state_d  = PREP;
                    is_div_d = op[1];
                    sa_d     = is_signed & op_a[XLEN-1];
                    sb_d     = is_signed & op_b[XLEN-1];
                    a_d      = a_mag;
                    b_d      = b_mag;
                    bz_d     = (op_b == '0);
                end
            end
            PREP: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
`ifdef MULDIV_DIVZERO_FLAG_EN
                if (is_div_q && bz_q) state_d = FIX;
`endif
            end
            RUN: begin
                if (is_div_q) begin
                    if (!trial[XLEN+1])
                        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {msum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bz_q) begin
                    // Zero divisor: all-ones quotient, dividend passed through as remainder.
                    lo_d = '1;
                    hi_d = sa_q ? -a_q : a_q;
                end else begin
                    lo_d = quo;
                    hi_d = rem;
                end
                done_d  = 1'b1;
`ifdef MULDIV_DIVZERO_FLAG_EN
                dz_d    = is_div_q & bz_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | rd_req);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs arithmetic model, corner sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, rd_req, flush;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic        div_zero;
    localparam int DZ_LAT = 3;
`else
    localparam int DZ_LAT = 35;
`endif

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .rd_req(rd_req), .flush(flush), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
`ifdef MULDIV_DIVZERO_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (lat = negedges after acceptance).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output int lat);
        op = o; op_a = a; op_b = b; start = 1'b1; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done) break;
        end
        rh = hi; rl = lo;
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint x, y, q, r;
        logic [63:0] p;
        case (o)
            3'd0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                {h, l} = p;
            end
            3'd1: begin
                p = {32'b0, a} * {32'b0, b};
                {h, l} = p;
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (o == 3'd3) begin
                    l = a / b;
                    h = a % b;
                end else begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    q = x / y;
                    r = x % y;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
        return (o[1] && b == 32'd0) ? DZ_LAT : 35;
    endfunction

    vec_t        vecs[9];
    logic [31:0] rh, rl, eh, el;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          lat;

    initial begin
        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
        vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        vecs[5] = '{3'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
        vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{3'd2, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};

        rst = 1'b1; start = 1'b0; rd_req = 1'b1; flush = 1'b0;
        op = 3'd0; op_a = '0; op_b = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("rst_dz", 32'(div_zero), 32'd0);
`endif
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table; consecutive calls also exercise start in the done cycle.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, lat);
            chk($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].b)));
`ifdef MULDIV_DIVZERO_FLAG_EN
            chk($sformatf("vec%0d_dz", i), 32'(div_zero), 32'(vecs[i].op[1] && vecs[i].b == 0));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = ra % 1000; rb = (rb % 40) - 20; end
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, rh, rl, lat);
            chk($sformatf("rnd%0d_op%0d_hi", i, ro), rh, eh);
            chk($sformatf("rnd%0d_op%0d_lo", i, ro), rl, el);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(ro, rb)));
        end

        // MFHI/MFLO during an operation stalls until busy falls; not in the done cycle.
        op = 3'd1; op_a = 32'd1000; op_b = 32'd1000; start = 1'b1; lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            lat = n;
            if (n == 1) chk("rd_busy_e1", 32'(busy), 32'd1);
            if (done) break;
            if (n >= 10) chk($sformatf("rd_stall_n%0d", n), 32'(stall), 32'd1);
            if (n == 9) rd_req = 1'b1;
        end
        chk("rd_lat", 32'(lat), 32'd35);
        chk("rd_done_stall", 32'(stall), 32'd0);
        chk("rd_done_hi", hi, 32'd0);
        chk("rd_done_lo", lo, 32'd1000000);
        rd_req = 1'b0;

        // Flush mid-RUN: no write, no done, and a fresh start is taken at once.
        op = 3'd3; op_a = 32'd99999; op_b = 32'd7; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_done", 32'(done), 32'd0);
        chk("fl_hi", hi, 32'd0);
        chk("fl_lo", lo, 32'd1000000);
        run_op(3'd3, 32'd12345, 32'd6, rh, rl, lat);
        chk("fl_next_hi", rh, 32'd3);
        chk("fl_next_lo", rl, 32'd2057);
        chk("fl_next_lat", 32'(lat), 32'd35);

        // Start ignored in IDLE when flushed or when the op code is illegal.
        start = 1'b1; flush = 1'b1; op = 3'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fl_idle_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'b100;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_busy", 32'(busy), 32'd0);

        // Asynchronous reset between edges in the middle of RUN.
        op = 3'd0; op_a = 32'hFFFF_FFFD; op_b = 32'd5; start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, rh, rl, lat);
        chk("arst_next_hi", rh, 32'hFFFF_FFFF);
        chk("arst_next_lo", rl, 32'hFFFF_FFF1);
        chk("arst_next_lat", 32'(lat), 32'd35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
